cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

- Parametrised hardware trace unit that sits beside the pipelined CPU core.
- Each cycle it samples the register-file writeback port and the data-memory write port, and pushes any activity into an internal FIFO. Each entry is tagged with a cycle stamp.
- Entries drain through a valid/ready readout port. This replaces per-cycle dumping of the full register and memory state with a compact, lossless-when-drained event log.
- Overflow is detected, counted and flagged sticky.

## Interface
Parameters:
- DATA_W, 32, width of register and memory data
- REG_ADDR_W, 5, register index width
- MEM_ADDR_W, 7, byte address width of data memory
- DEPTH, 16, FIFO entries; power of two, 2 or more
- CYC_W, 16, cycle-stamp width

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- trace_en_i  in  1  capture enable
- clear_i  in  1  synchronous flush
- wb_we_i  in  1  register-file write strobe
- wb_addr_i  in  REG_ADDR_W  destination register
- wb_data_i  in  DATA_W  writeback data
- mem_we_i  in  1  data-memory write strobe
- mem_addr_i  in  MEM_ADDR_W  store address
- mem_data_i  in  DATA_W  store data
- trace_valid_o  out  1  head entry available
- trace_ready_i  in  1  consumer accepts head entry
- trace_data_o  out  2+CYC_W+REG_ADDR_W+MEM_ADDR_W+2·DATA_W  head entry
- level_o  out  $clog2(DEPTH)+1  occupied entries
- overflow_o  out  1  sticky: at least one entry was dropped
- drop_cnt_o  out  16  dropped-entry count, saturating at 0xFFFF

## Operation
- Entry layout, MSB to LSB: {wb_v, mem_v, cycle, wb_addr, wb_data, mem_addr, mem_data}. Fields whose valid bit is 0 are driven as zero.
- Cycle counter, CYC_W bits:
  - Reset to 0.
  - Increments every cycle regardless of trace_en_i or clear_i.
  - Wraps from 2^CYC_W−1 to 0.
  - Stamp value = counter value before the sampling edge.
- Push request = trace_en_i & (wb_we_i | mem_we_i).
  - One entry per cycle. When both strobes are active in the same cycle, one entry is written with both valid bits set; nothing is split or delayed.
- FIFO: circular read and write pointers, each with an extra wrap bit. Full = DEPTH entries; empty = 0 entries.
- Push while full with no pop in the same cycle:
  - The entry is discarded.
  - overflow_o is set.
  - drop_cnt_o increments, saturating at 0xFFFF.
- Push and pop in the same cycle while full: both succeed, the push is accepted, and level_o is unchanged.
- Pop occurs when trace_valid_o & trace_ready_i. A pop while empty is impossible because valid is low.
- trace_data_o shows the head entry; it is held stable while valid is high and ready is low.
- clear_i:
  - Empties the FIFO, clears overflow_o and drop_cnt_o.
  - Has priority over a push or pop in the same cycle; that cycle's event is lost and is not counted as a drop.
  - The cycle counter is not affected.
- Reset mid-operation: all contents are lost immediately and asynchronously, and the outputs return to their reset values.

## Timing
- Reset values: trace_valid_o 0, trace_data_o 0, level_o 0, overflow_o 0, drop_cnt_o 0, cycle counter 0.
- Latency: an event sampled at edge N is visible on trace_valid_o and trace_data_o after edge N, so it is consumable in cycle N+1 if the FIFO was empty.
- Head data is read out combinationally from the storage array. A register array is sufficient; no RAM read latency applies.
- level_o, overflow_o and drop_cnt_o update at the same edge as the push, pop or clear that changes them.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- Macro: CPU_TRACE_SKIP_R0_EN.
- Defined: a writeback with wb_addr_i == 0 is treated as wb_we_i = 0.
  - If mem_we_i is also high, the entry is still pushed with wb_v = 0.
  - If mem_we_i is low, no entry is pushed.
- Undefined: writes to r0 are logged like any other register write.

## Test plan
- After reset: wb_we_i=1, wb_addr_i=3, wb_data_i=0x12 at stamp 5 → one entry {1,0,5,3,0x12,0,0}, level_o=1; valid drops after the pop.
- Same cycle: wb write (r8, 0xAA) plus store (addr 0x10, 0x55) → a single entry with both valid bits set and both payloads correct.
- DEPTH=4, ready=0, 6 consecutive events → level_o=4, overflow_o=1, drop_cnt_o=2; drain returns the first 4 events in order.
- Full FIFO with ready=1 and a new event in the same cycle → the push is accepted, level_o stays 4, drop_cnt_o unchanged.
- clear_i asserted together with an event while level_o=3 → the next cycle shows level_o=0, overflow_o=0 and valid=0, and the cycle counter continues uninterrupted.
- Write to r0 with data 7 → with CPU_TRACE_SKIP_R0_EN defined no entry is pushed; with it undefined one entry appears with wb_addr=0 and data 7.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Trace unit: logs writeback and store events with cycle stamps into a FIFO.
// Optional CPU_TRACE_SKIP_R0_EN suppresses writebacks to register r0.
module cpu_trace_buffer #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_ADDR_W = 7,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  trace_en_i,
  input  logic                  clear_i,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  input  logic                  mem_we_i,
  input  logic [MEM_ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0]     mem_data_i,
  output logic                  trace_valid_o,
  input  logic                  trace_ready_i,
  output logic [2+CYC_W+REG_ADDR_W+MEM_ADDR_W+2*DATA_W-1:0] trace_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                  overflow_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int PW      = PTR_W + 1;
  localparam int ENTRY_W = 2 + CYC_W + REG_ADDR_W + MEM_ADDR_W + 2 * DATA_W;

  logic [CYC_W-1:0]   cyc_q;
  logic [PTR_W:0]     wptr_q;
  logic [PTR_W:0]     rptr_q;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] entry;

  logic wb_hit;
  logic push_req;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop_ev;

`ifdef CPU_TRACE_SKIP_R0_EN
  assign wb_hit = wb_we_i & (wb_addr_i != '0);
`else
  assign wb_hit = wb_we_i;
`endif

  assign push_req = trace_en_i & (wb_hit | mem_we_i);

  // Payload fields of an inactive strobe are masked to zero.
  assign entry = {
    wb_hit,
    mem_we_i,
    cyc_q,
    wb_addr_i  & {REG_ADDR_W{wb_hit}},
    wb_data_i  & {DATA_W{wb_hit}},
    mem_addr_i & {MEM_ADDR_W{mem_we_i}},
    mem_data_i & {DATA_W{mem_we_i}}
  };

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                 (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign pop     = ~empty & trace_ready_i;
  assign push    = push_req & (~full | pop);
  assign drop_ev = push_req & full & ~pop;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      cyc_q <= cyc_q + CYC_W'(1);
      if (clear_i) begin
        wptr_q     <= '0;
        rptr_q     <= '0;
        overflow_o <= 1'b0;
        drop_cnt_o <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PW'(1);
        if (pop)  rptr_q <= rptr_q + PW'(1);
        if (drop_ev) begin
          overflow_o <= 1'b1;
          if (drop_cnt_o != 16'hFFFF)
            drop_cnt_o <= drop_cnt_o + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push & ~clear_i)
      mem_q[wptr_q[PTR_W-1:0]] <= entry;
  end

  assign trace_valid_o = ~empty;
  assign trace_data_o  = empty ? '0 : mem_q[rptr_q[PTR_W-1:0]];
  assign level_o       = wptr_q - rptr_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: directed cases then random traffic.
module tb_cpu_trace_buffer;

  localparam int DATA_W = 32;
  localparam int RA     = 5;
  localparam int MA     = 7;
  localparam int DEPTH  = 4;
  localparam int CYC_W  = 8;
  localparam int EW     = 2 + CYC_W + RA + MA + 2 * DATA_W;

  typedef logic [EW-1:0] ent_t;

  logic              clk;
  logic              rst_i;
  logic              trace_en_i;
  logic              clear_i;
  logic              wb_we_i;
  logic [RA-1:0]     wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic              mem_we_i;
  logic [MA-1:0]     mem_addr_i;
  logic [DATA_W-1:0] mem_data_i;
  logic              trace_valid_o;
  logic              trace_ready_i;
  logic [EW-1:0]     trace_data_o;
  logic [$clog2(DEPTH):0] level_o;
  logic              overflow_o;
  logic [15:0]       drop_cnt_o;

  cpu_trace_buffer #(
    .DATA_W(DATA_W), .REG_ADDR_W(RA), .MEM_ADDR_W(MA),
    .DEPTH(DEPTH), .CYC_W(CYC_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .trace_en_i(trace_en_i), .clear_i(clear_i),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_data_o(trace_data_o), .level_o(level_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t exp_q[$];
  int   count;
  int   drops;
  bit   ovf;
  int   cyc;
  int   checks;
  int   errors;

  task automatic chk(string name, logic [127:0] act, logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic ent_t mk(bit wv, bit mv, int c, int wa,
                              logic [31:0] wd, int ma, logic [31:0] md);
    return {wv, mv, CYC_W'(c),
            wv ? RA'(wa) : RA'(0), wv ? wd : 32'd0,
            mv ? MA'(ma) : MA'(0), mv ? md : 32'd0};
  endfunction

  // Monitor: the head is consumed whenever the model expects a handshake.
  always @(negedge clk) begin
    if (rst_i) begin
      chk("valid", 128'(trace_valid_o), 128'(exp_q.size() != 0));
      if (exp_q.size() != 0 && trace_ready_i)
        chk("head", 128'(trace_data_o), 128'(exp_q.pop_front()));
    end
  end

  task automatic model_reset();
    exp_q.delete();
    count = 0;
    drops = 0;
    ovf   = 0;
    cyc   = 0;
  endtask

  task automatic step(bit en, bit clr, bit ww, int wa, logic [31:0] wd,
                      bit mw, int ma, logic [31:0] md, bit rdy);
    bit wv;
    bit req;
    bit pop;
    trace_en_i    = en;
    clear_i       = clr;
    wb_we_i       = ww;
    wb_addr_i     = RA'(wa);
    wb_data_i     = wd;
    mem_we_i      = mw;
    mem_addr_i    = MA'(ma);
    mem_data_i    = md;
    trace_ready_i = rdy;
    @(posedge clk);
    #1;
    wv = ww;
`ifdef CPU_TRACE_SKIP_R0_EN
    if (wa == 0) wv = 0;
`endif
    req = en && (wv || mw);
    pop = (count > 0) && rdy;
    if (clr) begin
      exp_q.delete();
      count = 0;
      drops = 0;
      ovf   = 0;
    end else begin
      if (pop) count--;
      if (req) begin
        if (count < DEPTH) begin
          exp_q.push_back(mk(wv, mw, cyc, wa, wd, ma, md));
          count++;
        end else begin
          ovf = 1;
          if (drops < 65535) drops++;
        end
      end
    end
    cyc = (cyc + 1) % (1 << CYC_W);
    chk("level", 128'(level_o), 128'(count));
    chk("overflow", 128'(overflow_o), 128'(ovf));
    chk("drop_cnt", 128'(drop_cnt_o), 128'(drops));
  endtask

  task automatic idle(bit rdy);
    step(1, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic ev(bit rdy);
    step(1, 0, 1, int'($urandom_range(1, 31)), $urandom,
         $urandom_range(0, 1) == 1, int'($urandom_range(0, 127)), $urandom, rdy);
  endtask

  initial begin
    int stamp;
    checks = 0;
    errors = 0;
    rst_i = 0;
    trace_en_i = 0; clear_i = 0; wb_we_i = 0; wb_addr_i = '0;
    wb_data_i = '0; mem_we_i = 0; mem_addr_i = '0; mem_data_i = '0;
    trace_ready_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(trace_valid_o), 128'(0));
    chk("rst_data", 128'(trace_data_o), 128'(0));
    chk("rst_level", 128'(level_o), 128'(0));
    rst_i = 1;

    // First event at stamp 5, then popped.
    repeat (5) idle(0);
    step(1, 0, 1, 3, 32'h12, 0, 0, 0, 0);
    chk("first_entry", 128'(trace_data_o), 128'(mk(1, 0, 5, 3, 32'h12, 0, 0)));
    idle(1);
    chk("valid_after_pop", 128'(trace_valid_o), 128'(0));

    // Writeback and store in one cycle.
    step(1, 0, 1, 8, 32'hAA, 1, 32'h10, 32'h55, 0);
    chk("dual_entry", 128'(trace_data_o),
        128'(mk(1, 1, 7, 8, 32'hAA, 32'h10, 32'h55)));
    idle(1);

    // Overflow: six events into a four-deep FIFO.
    repeat (6) ev(0);
    chk("ovf_level", 128'(level_o), 128'(4));
    chk("ovf_flag", 128'(overflow_o), 128'(1));
    chk("ovf_drops", 128'(drop_cnt_o), 128'(2));
    ev(1);
    chk("full_pushpop_level", 128'(level_o), 128'(4));
    chk("full_pushpop_drops", 128'(drop_cnt_o), 128'(2));
    repeat (5) idle(1);

    // Clear with a simultaneous event.
    repeat (3) ev(0);
    chk("pre_clear_level", 128'(level_o), 128'(3));
    step(1, 1, 1, 4, 32'h1, 0, 0, 0, 0);
    chk("clr_level", 128'(level_o), 128'(0));
    chk("clr_ovf", 128'(overflow_o), 128'(0));
    chk("clr_valid", 128'(trace_valid_o), 128'(0));
    stamp = cyc;
    ev(0);
    chk("clr_stamp", 128'(trace_data_o[EW-3 -: CYC_W]), 128'(stamp));
    idle(1);

    // Writeback to r0.
    stamp = cyc;
    step(1, 0, 1, 0, 32'h7, 0, 0, 0, 0);
`ifdef CPU_TRACE_SKIP_R0_EN
    chk("r0_level", 128'(level_o), 128'(0));
`else
    chk("r0_level", 128'(level_o), 128'(1));
    chk("r0_entry", 128'(trace_data_o), 128'(mk(1, 0, stamp, 0, 32'h7, 0, 0)));
`endif
    idle(1);

    // Asynchronous reset mid-operation.
    repeat (2) ev(0);
    rst_i = 0;
    #1;
    chk("mid_rst_valid", 128'(trace_valid_o), 128'(0));
    chk("mid_rst_data", 128'(trace_data_o), 128'(0));
    chk("mid_rst_level", 128'(level_o), 128'(0));
    chk("mid_rst_ovf", 128'(overflow_o), 128'(0));
    chk("mid_rst_drops", 128'(drop_cnt_o), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_i = 1;

    // Random traffic; long enough to wrap the cycle stamp.
    for (int i = 0; i < 700; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 127)), $urandom,
           $urandom_range(0, 9) < 6);
    end
    repeat (DEPTH + 2) idle(1);
    chk("final_level", 128'(level_o), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
